ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0100_0000, the fetch address after reset.
REQ-002 SHALL have parameter MEM_BASE, default 32'h0100_0000, the lowest valid instruction byte address.
REQ-003 SHALL have parameter MEM_DEPTH, default 65536, the instruction memory size in bytes (multiple of 4).
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port imem_address, output, 32 bits: byte address driven to instruction memory; equals fetch_pc.
REQ-007 SHALL have port imem_data_in, output, 32 bits: constant 0.
REQ-008 SHALL have port imem_read_write, output, 1 bit: constant 0 (read only).
REQ-009 SHALL have port imem_data_out, input, 32 bits: combinational little-endian word at imem_address, valid in the same cycle.
REQ-010 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-011 SHALL have port redirect_pc, input, 32 bits: redirect target, sampled when redirect_valid=1.
REQ-012 SHALL have port inst_valid, output, 1 bit: the head entry is valid.
REQ-013 SHALL have port inst_ready, input, 1 bit: the consumer accepts the head entry.
REQ-014 SHALL have port inst, output, 32 bits: head instruction word.
REQ-015 SHALL have port inst_pc, output, 32 bits: head instruction address.
REQ-016 SHALL have port inst_fault, output, 1 bit: the head entry is a fetch fault.

Function
REQ-017 SHALL hold a 2-entry in-order FIFO of {pc, inst, fault} with occupancy count 0..2; inst_valid = (count != 0); inst/inst_pc/inst_fault come from the head entry.
REQ-018 SHALL perform a pop when inst_valid && inst_ready at a clock edge.
REQ-019 SHALL use an FSM with states RUN and HALT.
REQ-020 SHALL push in RUN when redirect_valid=0 and (count<2 or a pop occurs this cycle); push and pop in the same cycle leaves count unchanged.
REQ-021 SHALL, on a normal push, store {fetch_pc, imem_data_out, 0} and set fetch_pc <= fetch_pc + 4, modulo 2^32.
REQ-022 SHALL treat the fetch as a fault when fetch_pc[1:0] != 0, or fetch_pc < MEM_BASE, or fetch_pc + 4 > MEM_BASE + MEM_DEPTH (compared in 33 bits, no wrap).
REQ-023 SHALL, on a fault push, store {fetch_pc, 32'h0, 1}, hold fetch_pc, and enter HALT.
REQ-024 SHALL perform no pushes in HALT; imem_address holds the faulting fetch_pc.
REQ-025 SHALL give redirect_valid=1 priority over all other events: at that edge set count <= 0, fetch_pc <= redirect_pc, state <= RUN, and push nothing. A pop in that cycle counts as completed but has no effect on state.
REQ-026 SHALL hold all FIFO entries, fetch_pc and imem_address stable while count=2 and no pop occurs (no drop, no duplicate).
REQ-027 SHALL meet these latencies: first entry valid one cycle after reset deasserts; redirect target valid two edges after the redirect edge; one instruction per cycle sustained when inst_ready=1.

Reset
REQ-028 SHALL, at a clock edge with reset=1, set fetch_pc <= RESET_PC, count <= 0, state <= RUN, and all entry fields <= 0. The next cycle shows inst_valid=0, inst=0, inst_pc=0, inst_fault=0, imem_address=RESET_PC.
REQ-029 SHALL let reset override a simultaneous redirect, push or pop, including reset asserted mid-stream.

Verification
REQ-030 SHALL cover streaming: words A,B,C at 0x0100_0000/04/08 with inst_ready=1 -> (0x0100_0000,A), (0x0100_0004,B), (0x0100_0008,C) on consecutive cycles, inst_fault=0.
REQ-031 SHALL cover backpressure: inst_ready=0 -> count reaches 2, imem_address holds 0x0100_0008, head stays A; raise inst_ready -> A,B,C in order with none lost or repeated.
REQ-032 SHALL cover redirect with a full FIFO: redirect to 0x0100_0040 -> inst_valid=0 next cycle, then inst_pc=0x0100_0040 the following cycle.
REQ-033 SHALL cover a misaligned redirect: redirect to 0x0100_0042 -> one entry with inst_fault=1, inst=0, inst_pc=0x0100_0042; no further entries; imem_address held until the next redirect.
REQ-034 SHALL cover running off the end: MEM_DEPTH=16 -> four good entries 0x0100_0000..0x0100_000C, then a fault entry at 0x0100_0010 and HALT.
REQ-035 SHALL cover reset mid-stream: reset with FIFO full and inst_ready=1 -> next cycle inst_valid=0, imem_address=0x0100_0000; first entry valid one cycle after reset deasserts.

Source files
------------

// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential instruction fetch into a 2-entry FIFO with redirect and fault halt
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0100_0000,
  parameter logic [31:0] MEM_BASE  = 32'h0100_0000,
  parameter int          MEM_DEPTH = 65536
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  output logic [31:0] imem_data_in,
  output logic        imem_read_write,
  input  logic [31:0] imem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);
  typedef enum logic {RUN, HALT} state_t;
  localparam logic [32:0] LIMIT = {1'b0, MEM_BASE} + 33'(MEM_DEPTH);
  state_t      state_q, state_d;
  logic [1:0]  count_q, count_d, n;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0] inst0_q, inst0_d, inst1_q, inst1_d;
  logic        fault0_q, fault0_d, fault1_q, fault1_d;
  logic        pop, push, fault;
  logic [31:0] new_inst;
  assign imem_address    = fetch_pc_q;
  assign imem_data_in    = 32'h0;
  assign imem_read_write = 1'b0;
  assign inst_valid      = count_q != 2'd0;
  assign inst            = inst0_q;
  assign inst_pc         = pc0_q;
  assign inst_fault      = fault0_q;
  assign pop      = inst_valid && inst_ready;
  assign fault    = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q < MEM_BASE) ||
                    ({1'b0, fetch_pc_q} + 33'd4 > LIMIT);
  assign push     = (state_q == RUN) && !redirect_valid && (count_q != 2'd2 || pop);
  assign new_inst = fault ? 32'h0 : imem_data_out;
  assign n        = count_q - {1'b0, pop};
  // Next FIFO contents: shift on pop, then write the new entry at the first free slot
  always_comb begin
    pc0_d      = pop ? pc1_q : pc0_q;
    inst0_d    = pop ? inst1_q : inst0_q;
    fault0_d   = pop ? fault1_q : fault0_q;
    pc1_d      = pc1_q;
    inst1_d    = inst1_q;
    fault1_d   = fault1_q;
    count_d    = redirect_valid ? 2'd0 : n + {1'b0, push};
    fetch_pc_d = redirect_valid ? redirect_pc : (push && !fault) ? fetch_pc_q + 32'd4 : fetch_pc_q;
    state_d    = redirect_valid ? RUN : (push && fault) ? HALT : state_q;
    if (push && n == 2'd0) begin
      pc0_d    = fetch_pc_q;
      inst0_d  = new_inst;
      fault0_d = fault;
    end
    if (push && n == 2'd1) begin
      pc1_d    = fetch_pc_q;
      inst1_d  = new_inst;
      fault1_d = fault;
    end
  end
  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      count_q    <= 2'd0;
      fetch_pc_q <= RESET_PC;
      pc0_q      <= 32'h0;
      pc1_q      <= 32'h0;
      inst0_q    <= 32'h0;
      inst1_q    <= 32'h0;
      fault0_q   <= 1'b0;
      fault1_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
      inst0_q    <= inst0_d;
      inst1_q    <= inst1_d;
      fault0_q   <= fault0_d;
      fault1_q   <= fault1_d;
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: table-driven check of fetch streaming, backpressure, redirects, faults and reset
module tb_ifetch_unit;
  localparam logic [31:0] B = 32'h0100_0000;
  logic clock = 1'b0;
  logic reset;
  logic [31:0] addr, din, dout, rpc, ins, ipc;
  logic rw, rv, rdy, iv, ifl;
  logic [31:0] addr16, din16, dout16, ins16, ipc16;
  logic rw16, iv16, ifl16;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic        ef;
    logic [31:0] eaddr;
  } vec_t;
  vec_t v[30];
  vec_t e16[8];
  always #5 clock = ~clock;
  assign dout   = ~addr;
  assign dout16 = ~addr16;
  ifetch_unit dut (
    .clock(clock), .reset(reset), .imem_address(addr), .imem_data_in(din),
    .imem_read_write(rw), .imem_data_out(dout), .redirect_valid(rv), .redirect_pc(rpc),
    .inst_valid(iv), .inst_ready(rdy), .inst(ins), .inst_pc(ipc), .inst_fault(ifl)
  );
  ifetch_unit #(.MEM_DEPTH(16)) dut16 (
    .clock(clock), .reset(reset), .imem_address(addr16), .imem_data_in(din16),
    .imem_read_write(rw16), .imem_data_out(dout16), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(iv16), .inst_ready(1'b1), .inst(ins16), .inst_pc(ipc16), .inst_fault(ifl16)
  );
  function automatic vec_t mk(logic r, logic [31:0] p, logic y, logic ev, logic [31:0] epc, logic ef, logic [31:0] ea);
    vec_t t;
    t.rv = r; t.rpc = p; t.rdy = y; t.ev = ev; t.epc = epc; t.ef = ef; t.eaddr = ea;
    return t;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_head(string tag, vec_t t, logic v_, logic [31:0] a_, logic [31:0] i_, logic [31:0] p_, logic f_);
    chk({tag, " valid"}, {31'h0, v_}, {31'h0, t.ev});
    chk({tag, " addr"}, a_, t.eaddr);
    if (t.ev) begin
      chk({tag, " pc"}, p_, t.epc);
      chk({tag, " fault"}, {31'h0, f_}, {31'h0, t.ef});
      chk({tag, " inst"}, i_, t.ef ? 32'h0 : ~t.epc);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  initial begin
    v[0]  = mk(0, 0, 1, 0, 0, 0, B);
    v[1]  = mk(0, 0, 1, 1, B, 0, B + 4);
    v[2]  = mk(0, 0, 1, 1, B + 4, 0, B + 8);
    v[3]  = mk(0, 0, 0, 1, B + 8, 0, B + 12);
    v[4]  = mk(0, 0, 0, 1, B + 8, 0, B + 16);
    v[5]  = mk(0, 0, 0, 1, B + 8, 0, B + 16);
    v[6]  = mk(1, B, 0, 1, B + 8, 0, B + 16);
    v[7]  = mk(0, 0, 0, 0, 0, 0, B);
    v[8]  = mk(0, 0, 0, 1, B, 0, B + 4);
    v[9]  = mk(0, 0, 0, 1, B, 0, B + 8);
    v[10] = mk(0, 0, 0, 1, B, 0, B + 8);
    v[11] = mk(0, 0, 1, 1, B, 0, B + 8);
    v[12] = mk(0, 0, 1, 1, B + 4, 0, B + 12);
    v[13] = mk(1, B + 32'h40, 1, 1, B + 8, 0, B + 16);
    v[14] = mk(0, 0, 1, 0, 0, 0, B + 32'h40);
    v[15] = mk(1, B + 32'h42, 1, 1, B + 32'h40, 0, B + 32'h44);
    v[16] = mk(0, 0, 0, 0, 0, 0, B + 32'h42);
    v[17] = mk(0, 0, 0, 1, B + 32'h42, 1, B + 32'h42);
    v[18] = mk(0, 0, 1, 1, B + 32'h42, 1, B + 32'h42);
    v[19] = mk(0, 0, 1, 0, 0, 0, B + 32'h42);
    v[20] = mk(1, B + 32'h100, 1, 0, 0, 0, B + 32'h42);
    v[21] = mk(0, 0, 1, 0, 0, 0, B + 32'h100);
    v[22] = mk(1, 32'h00FF_FFFC, 1, 1, B + 32'h100, 0, B + 32'h104);
    v[23] = mk(0, 0, 0, 0, 0, 0, 32'h00FF_FFFC);
    v[24] = mk(1, B + 32'hFFFC, 0, 1, 32'h00FF_FFFC, 1, 32'h00FF_FFFC);
    v[25] = mk(0, 0, 0, 0, 0, 0, B + 32'hFFFC);
    v[26] = mk(0, 0, 0, 1, B + 32'hFFFC, 0, B + 32'h10000);
    v[27] = mk(0, 0, 1, 1, B + 32'hFFFC, 0, B + 32'h10000);
    v[28] = mk(0, 0, 1, 1, B + 32'h10000, 1, B + 32'h10000);
    v[29] = mk(0, 0, 1, 0, 0, 0, B + 32'h10000);
    e16[0] = mk(0, 0, 1, 0, 0, 0, B);
    e16[1] = mk(0, 0, 1, 1, B, 0, B + 4);
    e16[2] = mk(0, 0, 1, 1, B + 4, 0, B + 8);
    e16[3] = mk(0, 0, 1, 1, B + 8, 0, B + 12);
    e16[4] = mk(0, 0, 1, 1, B + 12, 0, B + 16);
    e16[5] = mk(0, 0, 1, 1, B + 16, 1, B + 16);
    e16[6] = mk(0, 0, 1, 0, 0, 0, B + 16);
    e16[7] = mk(0, 0, 1, 0, 0, 0, B + 16);
    reset = 1'b1; rv = 1'b0; rpc = 32'h0; rdy = 1'b0;
    step();
    step();
    chk("reset valid", {31'h0, iv}, 32'h0);
    chk("reset inst", ins, 32'h0);
    chk("reset pc", ipc, 32'h0);
    chk("reset fault", {31'h0, ifl}, 32'h0);
    chk("reset addr", addr, B);
    chk("reset data_in", din, 32'h0);
    chk("reset rw", {31'h0, rw}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rv = v[i].rv; rpc = v[i].rpc; rdy = v[i].rdy;
      chk_head($sformatf("vec%0d", i), v[i], iv, addr, ins, ipc, ifl);
      if (i < 8) chk_head($sformatf("depth16 k%0d", i), e16[i], iv16, addr16, ins16, ipc16, ifl16);
      step();
    end
    rv = 1'b1; rpc = B; rdy = 1'b0;
    step();
    rv = 1'b0;
    step();
    step();
    step();
    chk("full before reset", {31'h0, iv}, 32'h1);
    chk("full addr", addr, B + 8);
    rdy = 1'b1; reset = 1'b1;
    step();
    chk("midreset valid", {31'h0, iv}, 32'h0);
    chk("midreset addr", addr, B);
    chk("midreset inst", ins, 32'h0);
    chk("midreset pc", ipc, 32'h0);
    reset = 1'b0;
    chk("post reset idle", {31'h0, iv}, 32'h0);
    step();
    chk("post reset valid", {31'h0, iv}, 32'h1);
    chk("post reset pc", ipc, B);
    chk("post reset inst", ins, ~B);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
